// File: rtl/stack_mem_pkg.sv
// Shared definitions for the stack/memory sequencer: op codes, FSM states, SP defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stack_mem_pkg;

   localparam logic [7:0] SP_INIT_DEF  = 8'hFF;  // empty stack, descending, pre-decrement
   localparam logic [7:0] SP_LIMIT_DEF = 8'hC0;  // lowest legal SP; reaching it means full

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_PUSH  = 3'd1,
      OP_POP   = 3'd2,
      OP_CALL  = 3'd3,
      OP_RET   = 3'd4,
      OP_LOAD  = 3'd5,
      OP_STORE = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_STK_DEC,
      S_MEM_WR,
      S_MEM_RD,
      S_STK_INC,
      S_DONE
   } state_e;

endpackage

// File: rtl/stack_mem_sequencer_if.sv
// Bundle between decoder/memory and the sequencer: command handshake, memory pins, results.
// Latency: n/a (wires only).
// Backpressure: cmd_ready low while a command is in flight.
//   slave  : sequencer side (takes cmd_valid/cmd_op/mem_dout, drives everything else)
//   master : decoder + memory side
interface stack_mem_sequencer_if;
   logic       cmd_valid;
   logic [2:0] cmd_op;
   logic       cmd_ready;
   logic [7:0] mem_dout;
   logic       mem_rd;
   logic       mem_wr;
   logic       mem_s2;
   logic       mem_s5;
   logic [7:0] sp_out;
   logic [7:0] rdata;
   logic       pc_load;
   logic       done;
   logic       err_ovf;
   logic       err_unf;

   modport slave (
      input  cmd_valid, cmd_op, mem_dout,
      output cmd_ready, mem_rd, mem_wr, mem_s2, mem_s5,
             sp_out, rdata, pc_load, done, err_ovf, err_unf
   );

   modport master (
      output cmd_valid, cmd_op, mem_dout,
      input  cmd_ready, mem_rd, mem_wr, mem_s2, mem_s5,
             sp_out, rdata, pc_load, done, err_ovf, err_unf
   );
endinterface

// File: rtl/stack_mem_sequencer_stack_ptr.sv
// Stack pointer register with increment/decrement and full/empty compares.
// Latency: new SP visible the cycle after inc/dec.
// Backpressure: none; caller guarantees no inc when empty and no dec when full.
//   clk, rst : clock, synchronous active-high reset (SP <- SP_INIT)
//   inc, dec : step SP by +1 / -1 (dec wins if both, never both in practice)
//   sp, full, empty : current SP, SP==SP_LIMIT, SP==SP_INIT
module stack_ptr
   import stack_mem_pkg::*;
#(
   parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
   parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       dec,
   output logic [7:0] sp,
   output logic       full,
   output logic       empty
);

   always_ff @(posedge clk) begin
      if (rst)      sp <= SP_INIT;
      else if (dec) sp <= sp - 8'd1;
      else if (inc) sp <= sp + 8'd1;
   end

   assign full  = (sp == SP_LIMIT);
   assign empty = (sp == SP_INIT);

endmodule

// File: rtl/stack_mem_sequencer.sv
// Multi-cycle stack/memory sequencer: owns SP, drives memory RD/WR/S2/S5 for PUSH/POP/CALL/RET/LOAD/STORE.
// Latency: accept->done PUSH/CALL/POP/RET 3, LOAD/STORE 2, NOP and rejected stack ops 1.
// Backpressure: cmd_ready high only in IDLE; one command in flight.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stack_mem_sequencer_if.slave (command, memory control pins, results)
module stack_mem_sequencer
   import stack_mem_pkg::*;
#(
   parameter logic [7:0] SP_INIT  = SP_INIT_DEF,
   parameter logic [7:0] SP_LIMIT = SP_LIMIT_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   stack_mem_sequencer_if.slave  bus
);

   state_e     state;
   op_e        op_q;
   logic [7:0] sp;
   logic       sp_full;
   logic       sp_empty;

   logic       cmd_ready_q;
   logic       mem_rd_q, mem_wr_q, mem_s2_q, mem_s5_q;
   logic       done_q, pc_load_q, err_ovf_q, err_unf_q;
   logic [7:0] rdata_q;

   stack_ptr #(
      .SP_INIT  (SP_INIT),
      .SP_LIMIT (SP_LIMIT)
   ) u_stack_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (state == S_STK_INC),
      .dec   (state == S_STK_DEC),
      .sp    (sp),
      .full  (sp_full),
      .empty (sp_empty)
   );

   // All outputs are registered: each is set on the transition into the state
   // that owns it, so the pins behave as Moore outputs of the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         op_q        <= OP_NOP;
         cmd_ready_q <= 1'b1;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_s2_q    <= 1'b0;
         mem_s5_q    <= 1'b0;
         done_q      <= 1'b0;
         pc_load_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
         rdata_q     <= 8'h00;
      end else begin
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         mem_s2_q  <= 1'b0;
         mem_s5_q  <= 1'b0;
         done_q    <= 1'b0;
         pc_load_q <= 1'b0;
         err_ovf_q <= 1'b0;
         err_unf_q <= 1'b0;

         case (state)
            S_IDLE: begin
               if (bus.cmd_valid) begin
                  op_q        <= op_e'(bus.cmd_op);
                  cmd_ready_q <= 1'b0;
                  case (op_e'(bus.cmd_op))
                     OP_PUSH, OP_CALL: begin
                        if (sp_full) begin
                           state     <= S_DONE;
                           done_q    <= 1'b1;
                           err_ovf_q <= 1'b1;
                        end else begin
                           state <= S_STK_DEC;
                        end
                     end
                     OP_POP, OP_RET: begin
                        if (sp_empty) begin
                           state     <= S_DONE;
                           done_q    <= 1'b1;
                           err_unf_q <= 1'b1;
                        end else begin
                           state    <= S_MEM_RD;
                           mem_rd_q <= 1'b1;
                           mem_s2_q <= 1'b1;
                        end
                     end
                     OP_LOAD: begin
                        state    <= S_MEM_RD;
                        mem_rd_q <= 1'b1;
                     end
                     OP_STORE: begin
                        state    <= S_MEM_WR;
                        mem_wr_q <= 1'b1;
                        mem_s5_q <= 1'b1;
                     end
                     default: begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                     end
                  endcase
               end
            end
            S_STK_DEC: begin
               // Only PUSH/CALL get here; CALL writes NPC (s5=0).
               state    <= S_MEM_WR;
               mem_wr_q <= 1'b1;
               mem_s2_q <= 1'b1;
               mem_s5_q <= (op_q == OP_PUSH);
            end
            S_MEM_WR: begin
               state  <= S_DONE;
               done_q <= 1'b1;
            end
            S_MEM_RD: begin
               rdata_q <= bus.mem_dout;
               if (op_q == OP_POP || op_q == OP_RET) begin
                  state <= S_STK_INC;
               end else begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end
            end
            S_STK_INC: begin
               state     <= S_DONE;
               done_q    <= 1'b1;
               pc_load_q <= (op_q == OP_RET);
            end
            S_DONE: begin
               state       <= S_IDLE;
               cmd_ready_q <= 1'b1;
            end
            default: begin
               state       <= S_IDLE;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_s2    = mem_s2_q;
   assign bus.mem_s5    = mem_s5_q;
   assign bus.sp_out    = sp;
   assign bus.rdata     = rdata_q;
   assign bus.pc_load   = pc_load_q;
   assign bus.done      = done_q;
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_unf   = err_unf_q;

endmodule

// File: doc/stack_mem_sequencer.md
Name: stack_mem_sequencer

Overview:
- Multi-cycle controller that owns the stack pointer and drives the data memory's control pins: RD, WR, S2 (SP/R0 address select) and S5 (RN/NPC data select).
- Executes PUSH, POP, CALL, RET, LOAD and STORE commands issued by the instruction decoder.
- Returns POP/LOAD data and RET target PC; flags stack overflow and underflow.
- Sits between the control unit and the data memory; SP value feeds the memory SP_in.

Parameters:
- SP_INIT, 8'hFF, reset/empty SP value; stack descends, pre-decrement.
- SP_LIMIT, 8'hC0, lowest legal SP; SP==SP_LIMIT means full.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 LOAD, 6 STORE, 7 reserved (treated as NOP)
- cmd_ready  out  1  high only in IDLE
- mem_dout  in  8  memory dataOut (combinational read)
- mem_rd  out  1  memory RD
- mem_wr  out  1  memory WR
- mem_s2  out  1  1 = address from SP, 0 = from R0
- mem_s5  out  1  1 = data from RN, 0 = from NPC
- sp_out  out  8  current SP, to memory SP_in
- rdata  out  8  captured read data (POP/LOAD/RET)
- pc_load  out  1  one-cycle pulse with done on a successful RET; rdata is new PC
- done  out  1  one-cycle completion pulse
- err_ovf  out  1  valid with done: PUSH/CALL rejected, stack full
- err_unf  out  1  valid with done: POP/RET rejected, stack empty

Behaviour:
- Reset values: sp_out=SP_INIT, rdata=0; all other outputs 0 except cmd_ready=1; state IDLE.
- Handshake: command accepted on the edge where cmd_valid && cmd_ready. cmd_op is sampled and latched then; later changes are ignored. One command in flight at a time.
- States: IDLE, STK_DEC, MEM_WR, MEM_RD, STK_INC, DONE.
- Memory controls are Moore outputs decoded from state plus the latched op; all are 0 outside MEM_WR and MEM_RD.
- PUSH: IDLE → STK_DEC (SP←SP−1 at exit) → MEM_WR (wr=1, s2=1, s5=1) → DONE.
- CALL: same path as PUSH with s5=0, so NPC is written.
- POP: IDLE → MEM_RD (rd=1, s2=1; rdata←mem_dout at exit) → STK_INC (SP←SP+1) → DONE.
- RET: same path as POP; pc_load=1 in DONE.
- LOAD: IDLE → MEM_RD (rd=1, s2=0) → DONE.
- STORE: IDLE → MEM_WR (wr=1, s2=0, s5=1) → DONE.
- NOP / op 7: IDLE → DONE.
- Latency from accept edge to done high: PUSH/CALL/POP/RET 3 cycles; LOAD/STORE 2; NOP 1. DONE always returns to IDLE next cycle, so cmd_ready is high the cycle after done.
- Overflow: PUSH/CALL accepted with SP==SP_LIMIT go directly to DONE with err_ovf=1. No write, SP unchanged.
- Underflow: POP/RET accepted with SP==SP_INIT go directly to DONE with err_unf=1. No read capture, SP unchanged, no pc_load.
- Errors do not block later commands.
- SP arithmetic is 8-bit; the limit checks guarantee it never wraps.
- rdata holds its value until the next read completes.
- rst asserted in any state: next cycle IDLE, SP=SP_INIT, no WR that cycle. A partially executed PUSH leaves memory untouched when reset lands in STK_DEC.

Decomposition:
- Shared package stack_mem_pkg: op code constants, state enum, SP_INIT/SP_LIMIT defaults.
- Sub-module stack_ptr: SP register with inc, dec and reset, plus full/empty compare outputs. The FSM stays in the top level.

Test Plan:
- Reset then PUSH with RN=8'hA5 → STK_DEC, then MEM_WR with wr=1, s2=1, s5=1, sp_out=8'hFE; mem[FE]=A5; done 3 cycles after accept, no errors.
- PUSH A5, then POP → rdata=8'hA5, sp_out back to 8'hFF, done 3 cycles after accept; POP again → done with err_unf=1, SP=FF, mem_rd never high.
- CALL with NPC=8'h3C then RET → CALL writes with s5=0 to addr FE; RET gives pc_load=1 with done, rdata=8'h3C, SP=FF.
- Repeat PUSH 63 times (SP=C0), PUSH once more → err_ovf=1, no wr pulse, sp_out stays 8'hC0.
- STORE with R0=8'h10, RN=8'h77, then LOAD → STORE shows s2=0, s5=1, wr=1; LOAD returns rdata=8'h77 in 2 cycles; SP unchanged at FF.
- Assert rst during STK_DEC of a PUSH → next cycle IDLE, cmd_ready=1, sp_out=FF, no write to any address.
